// File: rtl/led_sweep_rx.sv
`default_nettype none
// ============================================================================
// Module   : led_sweep_rx
// Brief    : Consumes counter valid strobes and sweeps a one-hot LED pattern
//            (rotate or bounce) across R/G/B banks, cycling colour per sweep.
// Revision : 1.0
// ============================================================================
module led_sweep_rx #(
    parameter int NB_LED = 5
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_hold,
    input  logic              i_mode,
    input  logic              i_dir,
    output logic [NB_LED-1:0] o_led_r,
    output logic [NB_LED-1:0] o_led_g,
    output logic [NB_LED-1:0] o_led_b,
    output logic              o_wrap
);

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } colour_t;

    typedef enum logic [0:0] {
        GO_RIGHT = 1'b0,
        GO_LEFT  = 1'b1
    } bstate_t;

    localparam logic [NB_LED-1:0] c_pos_lsb = {{(NB_LED-1){1'b0}}, 1'b1};
    localparam logic [NB_LED-1:0] c_pos_msb = {1'b1, {(NB_LED-1){1'b0}}};

    logic [NB_LED-1:0] r_pos;
    colour_t           r_colour;
    bstate_t           r_bstate;
    logic              r_bload;
    logic              r_wrap;
    logic [NB_LED-1:0] r_led_r;
    logic [NB_LED-1:0] r_led_g;
    logic [NB_LED-1:0] r_led_b;

    logic              w_adv;
    logic              w_go_left;
    logic [NB_LED-1:0] w_pos_nxt;
    colour_t           w_colour_nxt;
    bstate_t           w_bstate_nxt;
    logic              w_wrap_nxt;

    assign w_adv = i_valid & ~i_hold;

    // Bounce direction comes from i_dir only on the first accept after entering bounce mode.
    assign w_go_left = r_bload ? i_dir : (r_bstate == GO_LEFT);

    always_comb begin
        w_pos_nxt    = r_pos;
        w_colour_nxt = r_colour;
        w_bstate_nxt = r_bstate;
        w_wrap_nxt   = 1'b0;
        if (w_adv) begin
            if (!$onehot(r_pos)) begin
                w_pos_nxt = c_pos_lsb;
            end else if (!i_mode) begin
                if (i_dir) begin
                    if (r_pos[NB_LED-1]) begin
                        w_pos_nxt  = c_pos_lsb;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos << 1;
                    end
                end else begin
                    if (r_pos[0]) begin
                        w_pos_nxt  = c_pos_msb;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos >> 1;
                    end
                end
            end else begin
                if (w_go_left) begin
                    if (r_pos[NB_LED-1]) begin
                        w_pos_nxt    = r_pos >> 1;
                        w_bstate_nxt = GO_RIGHT;
                        w_wrap_nxt   = 1'b1;
                    end else begin
                        w_pos_nxt    = r_pos << 1;
                        w_bstate_nxt = GO_LEFT;
                    end
                end else begin
                    if (r_pos[0]) begin
                        w_pos_nxt    = r_pos << 1;
                        w_bstate_nxt = GO_LEFT;
                        w_wrap_nxt   = 1'b1;
                    end else begin
                        w_pos_nxt    = r_pos >> 1;
                        w_bstate_nxt = GO_RIGHT;
                    end
                end
            end
            if (w_wrap_nxt) begin
                case (r_colour)
                    RED:     w_colour_nxt = GREEN;
                    GREEN:   w_colour_nxt = BLUE;
                    default: w_colour_nxt = RED;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pos    <= c_pos_lsb;
            r_colour <= RED;
            r_bstate <= GO_LEFT;
            r_bload  <= 1'b0;
            r_wrap   <= 1'b0;
            r_led_r  <= c_pos_lsb;
            r_led_g  <= '0;
            r_led_b  <= '0;
        end else begin
            r_pos    <= w_pos_nxt;
            r_colour <= w_colour_nxt;
            r_bstate <= w_bstate_nxt;
            r_wrap   <= w_wrap_nxt;
            if (!i_mode) begin
                r_bload <= 1'b1;
            end else if (w_adv) begin
                r_bload <= 1'b0;
            end
            // Banks are registered from next-state so colour and position change together.
            r_led_r <= (w_colour_nxt == RED)   ? w_pos_nxt : '0;
            r_led_g <= (w_colour_nxt == GREEN) ? w_pos_nxt : '0;
            r_led_b <= (w_colour_nxt == BLUE)  ? w_pos_nxt : '0;
        end
    end

    assign o_led_r = r_led_r;
    assign o_led_g = r_led_g;
    assign o_led_b = r_led_b;
    assign o_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_sweep_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sweep_rx
// Brief    : Directed self-checking bench for led_sweep_rx (NB_LED = 5).
// Revision : 1.0
// ============================================================================
module tb_led_sweep_rx;

    localparam int NB_LED = 5;

    logic              clock;
    logic              i_reset;
    logic              i_valid;
    logic              i_hold;
    logic              i_mode;
    logic              i_dir;
    logic [NB_LED-1:0] o_led_r;
    logic [NB_LED-1:0] o_led_g;
    logic [NB_LED-1:0] o_led_b;
    logic              o_wrap;

    int n_checks;
    int n_errors;
    int n_wraps;

    led_sweep_rx #(.NB_LED(NB_LED)) u_dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_hold  (i_hold),
        .i_mode  (i_mode),
        .i_dir   (i_dir),
        .o_led_r (o_led_r),
        .o_led_g (o_led_g),
        .o_led_b (o_led_b),
        .o_wrap  (o_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] leds();
        return {o_led_r, o_led_g, o_led_b};
    endfunction

    // One single-cycle strobe; returns at the negedge where its result is visible.
    task automatic strobe();
        @(negedge clock);
        i_valid = 1'b1;
        @(negedge clock);
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        i_reset = 1'b0;
        @(negedge clock);
        i_reset = 1'b1;
    endtask

    logic [14:0] bounce_exp [9];
    logic        bounce_wrap [9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_reset  = 1'b0;
        i_valid  = 1'b0;
        i_hold   = 1'b0;
        i_mode   = 1'b0;
        i_dir    = 1'b1;

        bounce_exp[0] = {5'b00010, 5'b00000, 5'b00000}; bounce_wrap[0] = 1'b0;
        bounce_exp[1] = {5'b00100, 5'b00000, 5'b00000}; bounce_wrap[1] = 1'b0;
        bounce_exp[2] = {5'b01000, 5'b00000, 5'b00000}; bounce_wrap[2] = 1'b0;
        bounce_exp[3] = {5'b10000, 5'b00000, 5'b00000}; bounce_wrap[3] = 1'b0;
        bounce_exp[4] = {5'b00000, 5'b01000, 5'b00000}; bounce_wrap[4] = 1'b1;
        bounce_exp[5] = {5'b00000, 5'b00100, 5'b00000}; bounce_wrap[5] = 1'b0;
        bounce_exp[6] = {5'b00000, 5'b00010, 5'b00000}; bounce_wrap[6] = 1'b0;
        bounce_exp[7] = {5'b00000, 5'b00001, 5'b00000}; bounce_wrap[7] = 1'b0;
        bounce_exp[8] = {5'b00000, 5'b00000, 5'b00010}; bounce_wrap[8] = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        i_reset = 1'b1;
        @(negedge clock);
        check("reset_leds", 32'(leds()), 32'({5'b00001, 5'b00000, 5'b00000}));
        check("reset_wrap", 32'(o_wrap), 32'd0);

        // Rotate left, four moves then a wrap into green
        i_mode = 1'b0;
        i_dir  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            strobe();
            check("rotl_red", 32'(leds()), 32'({5'(1 << k), 5'b00000, 5'b00000}));
        end
        strobe();
        check("rotl_wrap_leds", 32'(leds()), 32'({5'b00000, 5'b00001, 5'b00000}));
        check("rotl_wrap_pulse", 32'(o_wrap), 32'd1);
        @(negedge clock);
        check("rotl_wrap_end", 32'(o_wrap), 32'd0);
        strobe();
        check("rotl_green", 32'(leds()), 32'({5'b00000, 5'b00010, 5'b00000}));

        // Asynchronous reset mid-sweep, checked away from any clock edge
        @(negedge clock);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_rst_leds", 32'(leds()), 32'({5'b00001, 5'b00000, 5'b00000}));
        check("async_rst_wrap", 32'(o_wrap), 32'd0);
        @(negedge clock);
        i_reset = 1'b1;

        // Rotate right from reset: immediate wrap to MSB in green, then 74 more
        i_dir = 1'b0;
        strobe();
        check("rotr_first", 32'(leds()), 32'({5'b00000, 5'b10000, 5'b00000}));
        check("rotr_first_wrap", 32'(o_wrap), 32'd1);
        n_wraps = 1;
        for (int k = 0; k < 74; k++) begin
            strobe();
            if (o_wrap) n_wraps++;
        end
        check("rotr_wrap_count", 32'(n_wraps), 32'd15);
        check("rotr_75_leds", 32'(leds()), 32'({5'b00001, 5'b00000, 5'b00000}));

        // Bounce from reset
        i_mode = 1'b1;
        i_dir  = 1'b1;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            strobe();
            check("bounce_leds", 32'(leds()), 32'(bounce_exp[k]));
            check("bounce_wrap", 32'(o_wrap), 32'(bounce_wrap[k]));
        end

        // Hold beats a continuously high valid
        @(negedge clock);
        i_hold  = 1'b1;
        i_valid = 1'b1;
        repeat (10) @(negedge clock);
        check("hold_leds", 32'(leds()), 32'({5'b00000, 5'b00000, 5'b00010}));
        check("hold_wrap", 32'(o_wrap), 32'd0);
        i_hold = 1'b0;
        @(negedge clock);
        check("cont_1", 32'(leds()), 32'({5'b00000, 5'b00000, 5'b00100}));
        @(negedge clock);
        check("cont_2", 32'(leds()), 32'({5'b00000, 5'b00000, 5'b01000}));
        @(negedge clock);
        check("cont_3", 32'(leds()), 32'({5'b00000, 5'b00000, 5'b10000}));
        i_valid = 1'b0;
        @(negedge clock);
        check("cont_stop", 32'(leds()), 32'({5'b00000, 5'b00000, 5'b10000}));

        // Mode switch mid-sweep: rotate to 00100, then bounce heading right
        i_mode = 1'b0;
        i_dir  = 1'b1;
        do_reset();
        strobe();
        strobe();
        check("switch_pre", 32'(leds()), 32'({5'b00100, 5'b00000, 5'b00000}));
        i_mode = 1'b1;
        i_dir  = 1'b0;
        strobe();
        check("switch_post", 32'(leds()), 32'({5'b00010, 5'b00000, 5'b00000}));
        check("switch_wrap", 32'(o_wrap), 32'd0);
        i_dir = 1'b1;
        strobe();
        check("switch_keep_dir", 32'(leds()), 32'({5'b00001, 5'b00000, 5'b00000}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
